// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural integer register bank.
package reg_file_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
  localparam int ZERO_REG     = 0;
endpackage

// File: rtl/reg_file_reg_we.sv
// One register-file word: DATA_W-bit register with write enable and
// asynchronous active-low clear.
module reg_we #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Next state: load new data when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  // Storage flop, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file. Word 0 is constant zero. Reads are
// combinational, with an optional same-cycle write-to-read bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0]   word_q [NUM_REGS];
  logic [NUM_REGS-1:1] wen;
  logic                wr_live;

  // Word 0 is not storage; it always reads as zero.
  assign word_q[ZERO_REG] = '0;

  // One-hot write decoder plus one storage word per non-zero address.
  // Address 0 has no decoder output, so writes to it vanish.
  for (genvar g = ZERO_REG + 1; g < NUM_REGS; g++) begin : g_word
    assign wen[g] = we && (waddr == ADDR_W'(g));

    reg_we #(
      .DATA_W (DATA_W)
    ) u_word (
      .clk   (clk),
      .rst_n (reset),
      .en_i  (wen[g]),
      .d_i   (wdata),
      .q_o   (word_q[g])
    );
  end

  // A write is "live" for bypass only outside reset and to a real register,
  // so reset keeps both read ports at zero even while we is high.
  assign wr_live = reset && we && (waddr != ADDR_W'(ZERO_REG));

  // Read port 1: stored word, overridden by in-flight write data on a hit.
  always_comb begin
    rdata1 = word_q[raddr1];
    if ((BYPASS != 0) && wr_live && (raddr1 == waddr)) rdata1 = wdata;
  end

  // Read port 2: same selection, decided independently of port 1.
  always_comb begin
    rdata2 = word_q[raddr2];
    if ((BYPASS != 0) && wr_live && (raddr2 == waddr)) rdata2 = wdata;
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one instance with bypass, one without,
// driven from the same inputs and checked against a scoreboard queue.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] b_rd1, b_rd2;
  logic [31:0] n_rd1, n_rd2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] b1;
    logic [31:0] b2;
    logic [31:0] n1;
    logic [31:0] n2;
  } exp_t;

  exp_t sb[$];

  reg_file #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (b_rd1),
    .rdata2 (b_rd2)
  );

  reg_file #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .BYPASS(0)) dut_nobyp (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (n_rd1),
    .rdata2 (n_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    we     = w;
    waddr  = wa;
    wdata  = wd;
    raddr1 = a1;
    raddr2 = a2;
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] n1, input logic [31:0] n2);
    exp_t e;
    e.tag = tag;
    e.b1  = b1;
    e.b2  = b2;
    e.n1  = n1;
    e.n2  = n2;
    sb.push_back(e);
  endtask

  // Let the combinational reads settle, then pop and compare.
  task automatic check();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 entries required 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (b_rd1 === e.b1) else begin
      errors++;
      $error("FAIL %s byp.rdata1 got %h required %h", e.tag, b_rd1, e.b1);
    end
    checks++;
    assert (b_rd2 === e.b2) else begin
      errors++;
      $error("FAIL %s byp.rdata2 got %h required %h", e.tag, b_rd2, e.b2);
    end
    checks++;
    assert (n_rd1 === e.n1) else begin
      errors++;
      $error("FAIL %s nobyp.rdata1 got %h required %h", e.tag, n_rd1, e.n1);
    end
    checks++;
    assert (n_rd2 === e.n2) else begin
      errors++;
      $error("FAIL %s nobyp.rdata2 got %h required %h", e.tag, n_rd2, e.n2);
    end
  endtask

  // Advance to 2 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Reset held low: reads are zero even with a bypass-shaped write present.
    #7;
    drive(1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd31);
    expect_rd("rst_low", 32'h0, 32'h0, 32'h0, 32'h0);
    check();
    #12;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    reset = 1'b1;
    tick();

    // Post-reset state; the write attempted during reset did not land.
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
    expect_rd("rst_r0_r1", 32'h0, 32'h0, 32'h0, 32'h0);
    check();
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd3);
    expect_rd("rst_r31_r3", 32'h0, 32'h0, 32'h0, 32'h0);
    check();

    // Write reg 5, then read it back with port 2 on reg 0.
    drive(1'b1, 5'd5, 32'hAFAFAFAF, 5'd5, 5'd0);
    expect_rd("wr5_pre", 32'hAFAFAFAF, 32'h0, 32'h0, 32'h0);
    check();
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    expect_rd("wr5_post", 32'hAFAFAFAF, 32'h0, 32'hAFAFAFAF, 32'h0);
    check();

    // Write to reg 0 is discarded and does not disturb reg 5.
    drive(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd5);
    expect_rd("wr0_pre", 32'h0, 32'hAFAFAFAF, 32'h0, 32'hAFAFAFAF);
    check();
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    expect_rd("wr0_post", 32'h0, 32'hAFAFAFAF, 32'h0, 32'hAFAFAFAF);
    check();

    // Same-cycle read of the address being written.
    drive(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    expect_rd("byp7_pre", 32'h12345678, 32'h12345678, 32'h11111111, 32'h11111111);
    check();
    tick();
    expect_rd("byp7_edge", 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
    check();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    expect_rd("byp7_post", 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
    check();

    // Only the matching port bypasses.
    drive(1'b1, 5'd7, 32'hCAFEBABE, 5'd7, 5'd5);
    expect_rd("byp_split", 32'hCAFEBABE, 32'hAFAFAFAF, 32'h12345678, 32'hAFAFAFAF);
    check();
    drive(1'b1, 5'd7, 32'hCAFEBABE, 5'd5, 5'd7);
    expect_rd("byp_split2", 32'hAFAFAFAF, 32'hCAFEBABE, 32'hAFAFAFAF, 32'h12345678);
    check();
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Fill every register with its own pattern, then read mirrored pairs.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h01010101 * 32'(i), 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      expect_rd($sformatf("pair_%0d", i),
                32'h01010101 * 32'(i), 32'h01010101 * 32'(32 - i),
                32'h01010101 * 32'(i), 32'h01010101 * 32'(32 - i));
      check();
      tick();
    end

    // Reset pulse mid-cycle clears a held value and blocks a pending write.
    drive(1'b1, 5'd9, 32'h5A5A5A5A, 5'd9, 5'd9);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    expect_rd("hold9", 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A);
    check();
    #2;
    reset = 1'b0;
    expect_rd("rst_mid9", 32'h0, 32'h0, 32'h0, 32'h0);
    check();
    drive(1'b1, 5'd9, 32'h77777777, 5'd9, 5'd4);
    expect_rd("rst_wr9", 32'h0, 32'h0, 32'h0, 32'h0);
    check();
    @(posedge clk);
    #3;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd4);
    reset = 1'b1;
    expect_rd("rst_rel9", 32'h0, 32'h0, 32'h0, 32'h0);
    check();
    tick();
    expect_rd("rst_stay9", 32'h0, 32'h0, 32'h0, 32'h0);
    check();

    // Leftover scoreboard entries mean an expectation was never compared.
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d entries required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Two-read, one-write register file of NUM_REGS × DATA_W words, used by the datapath as the architectural integer register bank. Register 0 is hardwired to zero. Writes commit on the rising clock edge. Reads are combinational, with optional same-cycle write-to-read bypass so that a decode-stage read observes a write being committed in the same cycle.

## Interface
- DATA_W, 32, word width in bits
- NUM_REGS, 32, number of registers (power of two)
- ADDR_W, 5, address width, equal to log2(NUM_REGS)
- BYPASS, 1, 1 = a read of the address being written returns wdata in the same cycle; 0 = the read returns the stored (old) value
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; clears every register to 0
- we  input  1  write enable, sampled on the rising edge of clk
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- raddr1  input  ADDR_W  read port 1 address
- raddr2  input  ADDR_W  read port 2 address
- rdata1  output  DATA_W  read port 1 data (combinational)
- rdata2  output  DATA_W  read port 2 data (combinational)

## Operation
- Storage is NUM_REGS words, each a DATA_W-bit edge-triggered register with a write enable.
- Reset:
  - reset low asynchronously forces every word to 0, regardless of clk.
  - While reset is low, rdata1 and rdata2 read 0 for any address.
  - The first write can commit on the first rising edge after reset is high.
- Write:
  - On a rising edge with we=1, reset=1 and waddr≠0, word[waddr] takes wdata.
  - Every other word holds its value.
  - A write to address 0 is silently discarded.
- Read:
  - rdataN is word[raddrN], selected combinationally by a NUM_REGS:1 multiplexer.
  - raddrN=0 always returns 0.
- Bypass (BYPASS=1):
  - If we=1, waddr≠0 and raddrN==waddr, rdataN returns wdata combinationally.
  - Each port decides independently; both ports may bypass in the same cycle.
- Bypass (BYPASS=0): rdataN shows the old value until the edge, and the new value after it.
- No arithmetic is performed. Data passes through unmodified at full DATA_W width.

## Timing
- Write latency is 1 edge. With BYPASS=0, a written value is visible on the read ports immediately after the committing edge.
- Read latency is 0 cycles: combinational from raddrN, and with BYPASS=1 also from we, waddr and wdata.
- Reset asserted mid-write: reset wins. The word ends at 0 even if a write edge coincides.
- Reset deasserted concurrently with a clock edge: the write on that edge is not guaranteed. Bench stimulus must keep reset transitions at least 1 ns away from rising edges.
- Simultaneous read and write of the same non-zero address follows the bypass rule above.
- Simultaneous write to address 0 and read of address 0 returns 0.
- There are no stall or handshake signals: a write is accepted every cycle we=1.

## Structure
- Shared package: DATA_W and NUM_REGS defaults, ADDR_W derivation, and the ZERO_REG=0 constant.
- Sub-module reg_we: a DATA_W-bit register with write enable and asynchronous active-low clear.
  - Instantiate NUM_REGS-1 copies in a generate loop (index 1..NUM_REGS-1).
  - Word 0 is a constant 0, not a flop.
- Top level contains the write-address decoder (one-hot enable per word), the two read multiplexers and the bypass comparators.

## Test plan
- Reset low for 20 ns, then high, then read addresses 0, 1 and 31 -> rdata1 = rdata2 = 32'h00000000.
- Write 32'hAFAFAFAF to reg 5, then read raddr1=5 and raddr2=0 -> rdata1 = 32'hAFAFAFAF, rdata2 = 32'h00000000.
- Write 32'hDEADBEEF to reg 0, then read raddr1=0 -> 32'h00000000; all other registers unchanged.
- BYPASS=1: in the same cycle set we=1, waddr=7, wdata=32'h12345678 and raddr1=raddr2=7 -> both ports read 32'h12345678 before the edge. With BYPASS=0, both ports read the prior value before the edge and 32'h12345678 after it.
- Fill regs 1..31 with value 32'h01010101×index, then read all pairs (i, 32−i) -> each port returns its own pattern with no cross-talk.
- Hold reg 9 = 32'h5A5A5A5A, then pulse reset low mid-cycle (not on an edge) -> rdata for addr 9 drops to 0 immediately and stays 0 after reset releases until rewritten.
